// File: rtl/arb4_grant_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb4_grant_ctrl_pkg
//  Description : Shared constants, state encoding and helpers for the
//                4-requester grant controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb4_grant_ctrl_pkg;

    localparam int REQ_N = 4;
    localparam int IDX_W = 2;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot grant vector for a requester index
    function automatic logic [REQ_N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [REQ_N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : arb4_grant_ctrl_pkg
`default_nettype wire

// File: rtl/arb4_grant_ctrl_prio_enc4_v.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc4_v
//  Description : 4-to-2 priority encoder with valid, highest index wins.
//                In rotating mode the search starts just below the previous
//                winner, so the previous winner is examined last.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc4_v
    import arb4_grant_ctrl_pkg::*;
(
    input  logic [REQ_N-1:0] req_i,
    input  logic             rr_en_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] offset;
    logic [REQ_N-1:0] req_rot;
    logic [IDX_W-1:0] enc_rot;

    // Rotate so slot k holds requester (k+offset) mod 4; slot 3 is then
    // requester last-1, slot 0 the previous winner itself.
    always_comb begin
        offset  = rr_en_i ? last_i : '0;
        req_rot = '0;
        for (int k = 0; k < REQ_N; k++) begin
            req_rot[k] = req_i[IDX_W'(k) + offset];
        end
    end

    // Encode the rotated vector, then undo the rotation (2-bit wrap = mod 4)
    always_comb begin
        enc_rot = '0;
        if (req_rot[3])      enc_rot = 2'd3;
        else if (req_rot[2]) enc_rot = 2'd2;
        else if (req_rot[1]) enc_rot = 2'd1;
        else                 enc_rot = 2'd0;
        valid_o = |req_rot;
        idx_o   = valid_o ? (enc_rot + offset) : '0;
    end

endmodule : prio_enc4_v
`default_nettype wire

// File: rtl/arb4_grant_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arb4_grant_ctrl
//  Description : Sequential 4-requester bus arbiter. Issues one registered
//                one-hot grant, held until the owner releases it or the hold
//                timeout expires; every release passes through one idle cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb4_grant_ctrl
    import arb4_grant_ctrl_pkg::*;
#(
    parameter logic RR_MODE  = 1'b0,
    parameter int   MAX_HOLD = 16,
    parameter int   CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_N-1:0] req_i,
    input  logic [REQ_N-1:0] done_i,
    output logic [REQ_N-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             busy_o,
    output logic             timeout_o
);

    // Counter value on which the grant is revoked (unused when MAX_HOLD==0)
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t           state_q;
    logic [REQ_N-1:0] gnt_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic             gnt_valid_q;
    logic             busy_q;
    logic             timeout_q;
    logic [IDX_W-1:0] last_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;

    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             owner_release;
    logic             hold_expired;

    prio_enc4_v u_prio_enc (
        .req_i   (req_i),
        .rr_en_i (RR_MODE == MODE_RR),
        .last_i  (last_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // Saturating hold counter, owner release and timeout conditions
    always_comb begin
        hold_cnt_d    = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
        owner_release = done_i[gnt_idx_q] | ~req_i[gnt_idx_q];
        hold_expired  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    end

    // Grant FSM with registered outputs; release has priority over timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            last_q      <= '0;
            hold_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timeout_q <= 1'b0;
                    if (win_valid) begin
                        state_q     <= ST_GRANT;
                        gnt_q       <= idx_to_onehot(win_idx);
                        gnt_idx_q   <= win_idx;
                        gnt_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        last_q      <= win_idx;
                        hold_cnt_q  <= '0;
                    end
                end
                ST_GRANT: begin
                    hold_cnt_q <= hold_cnt_d;
                    if (owner_release || hold_expired) begin
                        state_q     <= ST_IDLE;
                        gnt_q       <= '0;
                        gnt_idx_q   <= '0;
                        gnt_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        timeout_q   <= ~owner_release;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    gnt_q       <= '0;
                    gnt_idx_q   <= '0;
                    gnt_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    timeout_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign busy_o      = busy_q;
    assign timeout_o   = timeout_q;

endmodule : arb4_grant_ctrl
`default_nettype wire

// File: tb/tb_arb4_grant_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb4_grant_ctrl
//  Description : Scoreboard bench for arb4_grant_ctrl. A fixed-priority and a
//                round-robin instance (both MAX_HOLD=4) share the same directed
//                stimulus; each vector carries the hand-computed response of
//                both instances after the following clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb4_grant_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;

    logic [3:0] f_gnt, r_gnt;
    logic [1:0] f_idx, r_idx;
    logic       f_valid, r_valid, f_busy, r_busy, f_to, r_to;

    typedef struct packed {
        logic [3:0] fg;
        logic       ft;
        logic [3:0] rg;
        logic       rt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    bit   stim_done;

    arb4_grant_ctrl #(.RR_MODE(1'b0), .MAX_HOLD(4), .CNT_W(5)) u_fix (
        .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
        .gnt_o(f_gnt), .gnt_idx_o(f_idx), .gnt_valid_o(f_valid),
        .busy_o(f_busy), .timeout_o(f_to)
    );

    arb4_grant_ctrl #(.RR_MODE(1'b1), .MAX_HOLD(4), .CNT_W(5)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
        .gnt_o(r_gnt), .gnt_idx_o(r_idx), .gnt_valid_o(r_valid),
        .busy_o(r_busy), .timeout_o(r_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] g);
        if (g[3])      return 2'd3;
        else if (g[2]) return 2'd2;
        else if (g[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    // One vector: inputs before the edge, expected outputs after it
    task automatic vec(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                       input logic [3:0] fg, input logic ft,
                       input logic [3:0] rg, input logic rt);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        done  = dn;
        e.fg = fg; e.ft = ft; e.rg = rg; e.rt = rt;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge the DUTs present a new response; compare it
    initial begin
        exp_t        e;
        logic [8:0]  act, want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act  = {f_gnt, f_idx, f_valid, f_busy, f_to};
                want = {e.fg, enc(e.fg), |e.fg, |e.fg, e.ft};
                n_checks++;
                if (act !== want) begin
                    n_fail++;
                    $display("FAIL fixed_resp t=%0t got gnt=%b idx=%0d v=%b busy=%b to=%b want gnt=%b idx=%0d v=%b busy=%b to=%b",
                             $time, act[8:5], act[4:3], act[2], act[1], act[0],
                             want[8:5], want[4:3], want[2], want[1], want[0]);
                end
                act  = {r_gnt, r_idx, r_valid, r_busy, r_to};
                want = {e.rg, enc(e.rg), |e.rg, |e.rg, e.rt};
                n_checks++;
                if (act !== want) begin
                    n_fail++;
                    $display("FAIL rr_resp t=%0t got gnt=%b idx=%0d v=%b busy=%b to=%b want gnt=%b idx=%0d v=%b busy=%b to=%b",
                             $time, act[8:5], act[4:3], act[2], act[1], act[0],
                             want[8:5], want[4:3], want[2], want[1], want[0]);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        stim_done = 1'b0;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;

        // reset held with all requests active
        vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        vec(0, 4'b0101, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        // 0101: both grant idx2; done -> idle; fixed regrants 2, rr moves to 0
        vec(1, 4'b0101, 4'b0000, 4'b0100, 0, 4'b0100, 0);
        vec(1, 4'b0101, 4'b0100, 4'b0000, 0, 4'b0000, 0);
        vec(1, 4'b0101, 4'b0000, 4'b0100, 0, 4'b0001, 0);
        vec(1, 4'b0101, 4'b0000, 4'b0100, 0, 4'b0001, 0);
        // done[0]: ignored by fixed (owner 2), releases rr (owner 0)
        vec(1, 4'b0101, 4'b0001, 4'b0100, 0, 4'b0000, 0);
        vec(1, 4'b0101, 4'b0000, 4'b0100, 0, 4'b0100, 0);
        // fixed reaches hold limit -> timeout pulse
        vec(1, 4'b0101, 4'b0000, 4'b0000, 1, 4'b0100, 0);
        vec(1, 4'b0101, 4'b0000, 4'b0100, 0, 4'b0100, 0);
        vec(1, 4'b0101, 4'b0000, 4'b0100, 0, 4'b0100, 0);
        // rr: done on the hold-limit cycle -> release without timeout
        vec(1, 4'b0101, 4'b0100, 4'b0000, 0, 4'b0000, 0);
        vec(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        // timeout: req 0010 held, 4 grant cycles, pulse, regrant
        vec(1, 4'b0010, 4'b0000, 4'b0010, 0, 4'b0010, 0);
        vec(1, 4'b0010, 4'b0000, 4'b0010, 0, 4'b0010, 0);
        vec(1, 4'b0010, 4'b0000, 4'b0010, 0, 4'b0010, 0);
        vec(1, 4'b0010, 4'b0000, 4'b0010, 0, 4'b0010, 0);
        vec(1, 4'b0010, 4'b0000, 4'b0000, 1, 4'b0000, 1);
        vec(1, 4'b0010, 4'b0000, 4'b0010, 0, 4'b0010, 0);
        // non-owner done bits ignored; dropping req releases
        vec(1, 4'b0010, 4'b1101, 4'b0010, 0, 4'b0010, 0);
        vec(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        // reset mid-grant, then 1001 after reset -> idx3 in both modes
        vec(1, 4'b1000, 4'b0000, 4'b1000, 0, 4'b1000, 0);
        vec(0, 4'b1000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        vec(1, 4'b1001, 4'b0000, 4'b1000, 0, 4'b1000, 0);
        // all requesting, owner releases 2 cycles after grant: rr order 3,2,1,0,3
        vec(1, 4'b1111, 4'b0000, 4'b1000, 0, 4'b1000, 0);
        vec(1, 4'b1111, 4'b1000, 4'b0000, 0, 4'b0000, 0);
        vec(1, 4'b1111, 4'b0000, 4'b1000, 0, 4'b0100, 0);
        vec(1, 4'b1111, 4'b0000, 4'b1000, 0, 4'b0100, 0);
        vec(1, 4'b1111, 4'b1100, 4'b0000, 0, 4'b0000, 0);
        vec(1, 4'b1111, 4'b0000, 4'b1000, 0, 4'b0010, 0);
        vec(1, 4'b1111, 4'b0000, 4'b1000, 0, 4'b0010, 0);
        vec(1, 4'b1111, 4'b1010, 4'b0000, 0, 4'b0000, 0);
        vec(1, 4'b1111, 4'b0000, 4'b1000, 0, 4'b0001, 0);
        vec(1, 4'b1111, 4'b0000, 4'b1000, 0, 4'b0001, 0);
        vec(1, 4'b1111, 4'b1001, 4'b0000, 0, 4'b0000, 0);
        vec(1, 4'b1111, 4'b0000, 4'b1000, 0, 4'b1000, 0);
        vec(1, 4'b1111, 4'b0000, 4'b1000, 0, 4'b1000, 0);
        vec(1, 4'b1111, 4'b1000, 4'b0000, 0, 4'b0000, 0);
        vec(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);

        // let the monitor drain the scoreboard
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog got timeout want completion");
            $fatal(1, "watchdog expired");
        end
    end

endmodule : tb_arb4_grant_ctrl
`default_nettype wire
